// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
//
// Handshaked execute stage that performs one operation per transaction on two
// WIDTH-bit operands. It covers PASS_B, ADD, SUB, AND, OR, XOR, logical shifts
// and an optional iterative shift-and-add multiplier. It also holds a
// registered NZVC flag file. The result register holds its value until
// downstream accepts it. While a multiply is iterating, upstream is stalled.
//
// Optional feature macro: EXEC_MUL_EN
//   defined   : iterative multiplier, MUL state and busy logic are built in.
//   undefined : op 1010 is treated as an illegal op and busy is tied 0.
//
// Parameters
//   WIDTH      operand/result width (power of two, 8..64)
//   SHW        shift-amount width, derived as $clog2(WIDTH)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   upstream offers an operation
//   in_ready   unit accepts an operation this cycle
//   op         operation code
//   a, b       operands
//   shamt      shift distance for LSL/LSR
//   set_flags  update NZVC (ADD/SUB only)
//   out_valid  result register holds an unconsumed result
//   out_ready  downstream accepts the result
//   result     registered result
//   illegal    registered with result; the op code was illegal
//   flags      registered {N,Z,V,C}
//   busy       multiply in progress
// -----------------------------------------------------------------------------
module exec_unit #(
    parameter  int WIDTH = 64,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [3:0] OP_PASS_B = 4'b0000;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_AND    = 4'b0100;
    localparam logic [3:0] OP_OR     = 4'b0101;
    localparam logic [3:0] OP_XOR    = 4'b0110;
    localparam logic [3:0] OP_LSL    = 4'b1000;
    localparam logic [3:0] OP_LSR    = 4'b1001;
`ifdef EXEC_MUL_EN
    localparam logic [3:0] OP_MUL    = 4'b1010;
`endif

    logic [WIDTH-1:0] result_q;
    logic             illegal_q;
    logic [3:0]       flags_q;
    logic             out_valid_q;

    // Result register may be written this edge: empty, or draining now.
    logic can_write;
    logic accept;

    // Adder shared by ADD and SUB (SUB = a + ~b + 1).
    logic             sub_sel;
    logic [WIDTH-1:0] b_opnd;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;
    logic [3:0]       add_flags;

    // Single-cycle decode.
    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;
    logic             flag_upd;
    logic             start_mul;

    assign can_write = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;

    assign sub_sel   = (op == OP_SUB);
    assign b_opnd    = sub_sel ? ~b : b;
    assign sum_ext   = {1'b0, a} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, sub_sel};
    assign sum       = sum_ext[WIDTH-1:0];
    // Overflow: operands of equal sign produce a result of the other sign.
    assign sum_ovf   = (a[WIDTH-1] == b_opnd[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign add_flags = {sum[WIDTH-1], (sum == '0), sum_ovf, sum_ext[WIDTH]};

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        flag_upd    = 1'b0;
        start_mul   = 1'b0;
        unique case (op)
            OP_PASS_B: alu_res = b;
            OP_ADD, OP_SUB: begin
                alu_res  = sum;
                flag_upd = set_flags;
            end
            OP_AND:    alu_res = a & b;
            OP_OR:     alu_res = a | b;
            OP_XOR:    alu_res = a ^ b;
            OP_LSL:    alu_res = a << shamt;
            OP_LSR:    alu_res = a >> shamt;
`ifdef EXEC_MUL_EN
            OP_MUL:    start_mul = 1'b1;
`endif
            default:   alu_illegal = 1'b1;
        endcase
    end

`ifdef EXEC_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW:0]     cnt_q;
    logic [WIDTH-1:0] next_acc;
    logic             mul_write;
    logic [WIDTH-1:0] mul_value;

    assign next_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The last iteration (counter 1 -> 0) writes the result directly when
    // the result register is free. Otherwise the counter parks at 0 and the
    // finished accumulator waits for the register to drain.
    always_comb begin
        state_d   = state_q;
        mul_write = 1'b0;
        mul_value = acc_q;
        unique case (state_q)
            IDLE: begin
                if (accept && start_mul) state_d = MUL;
            end
            MUL: begin
                if (cnt_q != '0) mul_value = next_acc;
                if ((cnt_q == CNT_ONE || cnt_q == '0) && can_write) begin
                    mul_write = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == MUL);
    assign in_ready = (state_q != MUL) && can_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept && start_mul) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CNT_INIT;
        end else if (state_q == MUL && cnt_q != '0) begin
            acc_q    <= next_acc;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_ONE;
        end
    end
`else
    assign busy     = 1'b0;
    assign in_ready = can_write;
`endif

    // Result / flag register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q    <= '0;
            illegal_q   <= 1'b0;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            if (accept && !start_mul) begin
                result_q    <= alu_res;
                illegal_q   <= alu_illegal;
                out_valid_q <= 1'b1;
                if (flag_upd) flags_q <= add_flags;
            end
`ifdef EXEC_MUL_EN
            if (mul_write) begin
                result_q    <= mul_value;
                illegal_q   <= 1'b0;
                out_valid_q <= 1'b1;
            end
`endif
        end
    end

    assign result    = result_q;
    assign illegal   = illegal_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised, handshaked execute stage for the next-generation datapath: one operation per transaction on two WIDTH-bit operands. Covers the ALU operations, logical shifts, an iterative multi-cycle multiplier and a registered NZVC flag file. It sits between register read and memory/writeback. Unlike the single-cycle datapath, it stalls upstream with valid/ready while a multiply is in flight, and it holds its result until downstream accepts it.

## Interface
- WIDTH, 64, operand/result width; power of two, 8..64
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream offers an operation
- in_ready  out  1  unit accepts this cycle
- op  in  4  0000 PASS_B, 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 1000 LSL, 1001 LSR, 1010 MUL; all other codes illegal
- a  in  WIDTH  operand A (Rn)
- b  in  WIDTH  operand B (Rm/immediate)
- shamt  in  SHW  shift distance for LSL/LSR
- set_flags  in  1  update flags (honoured for ADD/SUB only)
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- illegal  out  1  registered with result; op code was illegal
- flags  out  4  registered {N,Z,V,C}
- busy  out  1  multiply in progress

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- in_ready = (state != MUL) && (!out_valid || out_ready). The unit takes new work in the same cycle the old result drains.
- FSM states:
  - IDLE: accept an op. A non-MUL op writes result/illegal and sets out_valid at the accept edge. A MUL op loads the multiplicand (a), multiplier (b), clears the accumulator, loads the counter with WIDTH, and goes to MUL.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left 1 and the multiplier right 1, and decrement the counter. The edge where the counter reaches 0 writes the accumulator to result, sets out_valid and returns to IDLE.
- Multiplier output is the low WIDTH bits of a*b (modular); signedness is irrelevant.
- Arithmetic: ADD = a+b, SUB = a+~b+1, both WIDTH bits wrapping.
- Flags: C = carry out of bit WIDTH-1 (SUB: 1 means no borrow). V = signed overflow. N = result[WIDTH-1]. Z = (result == 0).
- Flags update only at the accept edge of ADD/SUB with set_flags=1; otherwise they hold. Flags are never affected by MUL, shifts, logic or illegal ops.
- LSL/LSR: logical, zero fill, distance shamt (0..WIDTH-1); shamt 0 passes a.
- Illegal op: 1-cycle, result=0, illegal=1, flags unchanged.
- out_valid clears on transfer out unless a new result is written the same edge (then it stays 1 with the new data).
- busy = (state == MUL).

## Timing
- Reset (asynchronous assert, any state including mid-MUL): state IDLE, out_valid=0, result=0, illegal=0, flags=4'b0000, busy=0, counter/accumulator 0. Any in-flight multiply is discarded.
- Non-MUL latency: result visible the cycle after the accept edge. Throughput is 1/cycle when out_ready is held high.
- MUL latency: accept at edge E, result valid after edge E+WIDTH. in_ready=0 for cycles E+1..E+WIDTH.
- Back-pressure: with out_valid=1 and out_ready=0, in_ready=0 and result/illegal/flags are stable.
- In state MUL, in_valid is ignored. A pending unconsumed result does not block MUL iteration. The final write of the MUL result waits in MUL (counter held at 0) while out_valid && !out_ready.
- Flags become visible one cycle after the accept edge, aligned with out_valid of that op.

## Configuration
- EXEC_MUL_EN defined: iterative multiplier, MUL state and busy logic compiled in as above.
- EXEC_MUL_EN undefined: no MUL state and no multiplier registers. Op 1010 is handled as illegal (1-cycle, result=0, illegal=1), and busy is tied 0.

## Test plan
- After reset deasserts: out_valid=0, flags=0000, in_ready=1. ADD a=5, b=3, set_flags=1 -> next cycle result=8, flags=0000.
- SUB a=3, b=3, set_flags=1 -> result=0, flags N=0 Z=1 V=0 C=1. Then ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_flags=1 -> result=0x8000_0000_0000_0000, flags=1010.
- MUL a=0x1234, b=0x10 with out_ready=1 -> busy for 64 cycles, in_ready=0 throughout, result=0x12340 after edge E+64. MUL a=-1, b=-1 -> result=1.
- out_ready=0: issue LSL a=1, shamt=63 -> result=0x8000_0000_0000_0000 held and in_ready=0 for 10 cycles. Raise out_ready -> a queued XOR is accepted in that same cycle.
- Assert reset at cycle 20 of a MUL -> out_valid=0, busy=0, flags=0000 immediately. After release, PASS_B b=7 -> result=7.
- op=1111 -> result=0, illegal=1, flags unchanged. Without EXEC_MUL_EN, op=1010 -> same response.
